// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: pipelined main-decoder control path.
// Decodes the ID-stage opcode into a control word and carries it through the
// ID/EX, EX/MEM and MEM/WB registers together with a valid bit and the
// write-back destination register. Detects load-use hazards (one-cycle stall
// plus bubble) and flushes IF/ID on a taken branch resolved in EX.
// Optional feature macro: JUMP_EN (adds J decode and the 'jump' output).
module ctrl_pipe_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [5:0]              id_opcode,
    input  logic [REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]   id_rt,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    ex_branch_taken,
    output logic                    stall,
    output logic                    if_id_flush,
    output logic                    illegal_op,
`ifdef JUMP_EN
    output logic                    jump,
`endif
    output logic [8+ALU_OP_W-1:0]   ex_ctrl,
    output logic [4:0]              mem_ctrl,
    output logic [1:0]              wb_ctrl,
    output logic                    ex_valid,
    output logic                    mem_valid,
    output logic                    wb_valid,
    output logic [REG_ADDR_W-1:0]   ex_dst,
    output logic [REG_ADDR_W-1:0]   mem_dst,
    output logic [REG_ADDR_W-1:0]   wb_dst
);

    typedef enum logic [5:0] {
        OP_R    = 6'b000000,
        OP_LW   = 6'b100011,
        OP_SW   = 6'b101011,
        OP_BEQ  = 6'b000100,
        OP_ADDI = 6'b001000,
        OP_J    = 6'b000010
    } opcode_e;

    // ex_ctrl bit positions, LSB upwards. The top bit is a spare that is
    // always 0: the word is one bit wider than its named fields.
    localparam int B_REG_W   = 0;
    localparam int B_MEM_R   = 3;

    logic                  dec_reg_dst;
    logic                  dec_alu_src;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  dec_branch;
    logic                  dec_mem_r;
    logic                  dec_mem_w;
    logic                  dec_mem_to_reg;
    logic                  dec_reg_w;
    logic                  dec_legal;
    logic                  dec_rt_read;
    logic                  dec_is_j;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic [8+ALU_OP_W-1:0] dec_word;

    logic                  uses_ex_dst;
    logic                  load_use;
    logic                  jump_int;
    logic                  bubble;

    // Main decoder: opcode -> control fields, destination and rt usage
    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = '0;
        dec_branch     = 1'b0;
        dec_mem_r      = 1'b0;
        dec_mem_w      = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_w      = 1'b0;
        dec_legal      = 1'b1;
        dec_rt_read    = 1'b0;
        dec_is_j       = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec_reg_dst     = 1'b1;
                dec_reg_w       = 1'b1;
                dec_alu_op[2:0] = 3'b010;
                dec_rt_read     = 1'b1;
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_w      = 1'b1;
                dec_mem_r      = 1'b1;
            end
            OP_SW: begin
                dec_alu_src = 1'b1;
                dec_mem_w   = 1'b1;
                dec_rt_read = 1'b1;
            end
            OP_BEQ: begin
                dec_branch      = 1'b1;
                dec_alu_op[2:0] = 3'b001;
                dec_rt_read     = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_src     = 1'b1;
                dec_reg_w       = 1'b1;
                dec_alu_op[2:0] = 3'b110;
            end
`ifdef JUMP_EN
            OP_J: begin
                dec_is_j = 1'b1;
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase

        dec_dst = dec_reg_dst ? id_rd : id_rt;
        // r0 is hard-wired; never request a write to it
        if (dec_dst == '0) begin
            dec_reg_w = 1'b0;
        end

        dec_word = {1'b0, dec_reg_dst, dec_alu_src, dec_alu_op, dec_branch,
                    dec_mem_r, dec_mem_w, dec_mem_to_reg, dec_reg_w};
    end

`ifdef JUMP_EN
    assign jump_int = id_valid & dec_is_j & ~ex_branch_taken;
    assign jump     = jump_int;
`else
    assign jump_int = 1'b0;
`endif

    // Hazard, flush and bubble selection for the ID/EX register
    always_comb begin
        uses_ex_dst = (ex_dst == id_rs) | (dec_rt_read & (ex_dst == id_rt));
        load_use    = ex_valid & ex_ctrl[B_MEM_R] & id_valid
                      & (ex_dst != '0) & uses_ex_dst;
        // A taken branch discards the ID instruction, so holding it is pointless
        stall       = load_use & ~ex_branch_taken;
        if_id_flush = ex_branch_taken | jump_int;
        illegal_op  = id_valid & ~dec_legal;
        // A J has done its work by redirecting fetch; it travels on as a bubble
        bubble      = ~id_valid | ~dec_legal | load_use | ex_branch_taken
                      | jump_int;
    end

    // ID/EX register: decoded word, or a bubble on hazard/flush/empty ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl  <= '0;
            ex_valid <= 1'b0;
            ex_dst   <= '0;
        end else if (bubble) begin
            ex_ctrl  <= '0;
            ex_valid <= 1'b0;
            ex_dst   <= '0;
        end else begin
            ex_ctrl  <= dec_word;
            ex_valid <= 1'b1;
            ex_dst   <= dec_dst;
        end
    end

    // EX/MEM register: always advances, keeps the memory and write-back fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ctrl  <= '0;
            mem_valid <= 1'b0;
            mem_dst   <= '0;
        end else begin
            mem_ctrl  <= ex_ctrl[B_REG_W +: 5];
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
        end
    end

    // MEM/WB register: always advances, keeps only the write-back fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctrl  <= '0;
            wb_valid <= 1'b0;
            wb_dst   <= '0;
        end else begin
            wb_ctrl  <= mem_ctrl[1:0];
            wb_valid <= mem_valid;
            wb_dst   <= mem_dst;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed scenarios plus a randomized
// run against a record-level pipeline model. Honours JUMP_EN if defined.
module tb_ctrl_pipe_unit;

    localparam int RW = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [5:0]    id_opcode;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          ex_branch_taken;
    logic          stall, if_id_flush, illegal_op;
`ifdef JUMP_EN
    logic          jump;
`endif
    logic [8+AW-1:0] ex_ctrl;
    logic [4:0]      mem_ctrl;
    logic [1:0]      wb_ctrl;
    logic            ex_valid, mem_valid, wb_valid;
    logic [RW-1:0]   ex_dst, mem_dst, wb_dst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.REG_ADDR_W(RW), .ALU_OP_W(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .if_id_flush(if_id_flush), .illegal_op(illegal_op),
`ifdef JUMP_EN
        .jump(jump),
`endif
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit       reg_dst, alu_src, branch, mem_r, mem_w, mem_to_reg, reg_w;
        bit [2:0] alu_op;
        bit [4:0] dst;
    } ent_t;

    ent_t m_ex, m_mem, m_wb;

    function automatic ent_t blank();
        ent_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic ent_t ref_decode(input bit [5:0] op, input bit [4:0] rt,
                                        input bit [4:0] rd, output bit legal,
                                        output bit rt_read);
        ent_t e = blank();
        legal   = 1'b1;
        rt_read = 1'b0;
        e.v     = 1'b1;
        case (op)
            6'b000000: begin e.reg_dst = 1; e.reg_w = 1; e.alu_op = 3'b010; rt_read = 1; end
            6'b100011: begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_w = 1; e.mem_r = 1; end
            6'b101011: begin e.alu_src = 1; e.mem_w = 1; rt_read = 1; end
            6'b000100: begin e.branch = 1; e.alu_op = 3'b001; rt_read = 1; end
            6'b001000: begin e.alu_src = 1; e.reg_w = 1; e.alu_op = 3'b110; end
`ifdef JUMP_EN
            6'b000010: begin end
`endif
            default: legal = 1'b0;
        endcase
        e.dst = e.reg_dst ? rd : rt;
        if (e.dst == 5'd0) e.reg_w = 1'b0;
        return e;
    endfunction

    function automatic bit [8+AW-1:0] pack_ex(input ent_t e);
        return {1'b0, e.reg_dst, e.alu_src, e.alu_op, e.branch, e.mem_r,
                e.mem_w, e.mem_to_reg, e.reg_w};
    endfunction

    function automatic bit [4:0] pack_mem(input ent_t e);
        return {e.branch, e.mem_r, e.mem_w, e.mem_to_reg, e.reg_w};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs,
                         input bit [4:0] rt, input bit [4:0] rd, input bit br);
        id_valid        = v;
        id_opcode       = op;
        id_rs           = rs;
        id_rt           = rt;
        id_rd           = rd;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // rst held since time 0
        checks++;
        if ({ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got v=%b%b%b ex=%h mem=%h wb=%h, want all 0",
                     ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl);
        end
        checks++;
        if ({stall, if_id_flush, illegal_op} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb: got %b want 000", {stall, if_id_flush, illegal_op});
        end
        rst = 1'b0;
        drive(1, 6'b001000, 5'd1, 5'd5, 5'd0, 0);
        tick();
        drive(1, 6'b000000, 5'd1, 5'd2, 5'd7, 0);
        tick();
        idle();
        checks++;
        if ({ex_valid, mem_valid} !== 2'b11) begin
            errors++;
            $display("FAIL reset_prefill: got ex/mem valid=%b want 11", {ex_valid, mem_valid});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst} !== '0) begin
            errors++;
            $display("FAIL reset_async: got v=%b%b%b ex=%h mem=%h wb=%h dst=%0d/%0d, want all 0",
                     ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst);
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        drive(1, 6'b001000, 5'd1, 5'd5, 5'd9, 0);
        tick();
        idle();
        checks++;
        if ({ex_valid, ex_ctrl[7:5], ex_ctrl, ex_dst} !== {1'b1, 3'b110, 11'b00111000001, 5'd5}) begin
            errors++;
            $display("FAIL addi_ex: got v=%b ctrl=%b dst=%0d want v=1 ctrl=00111000001 dst=5",
                     ex_valid, ex_ctrl, ex_dst);
        end
        tick();
        checks++;
        if ({mem_valid, mem_ctrl, mem_dst} !== {1'b1, 5'b00001, 5'd5}) begin
            errors++;
            $display("FAIL addi_mem: got v=%b ctrl=%b dst=%0d want 1/00001/5",
                     mem_valid, mem_ctrl, mem_dst);
        end
        tick();
        checks++;
        if ({wb_valid, wb_ctrl, wb_dst} !== {1'b1, 2'b01, 5'd5}) begin
            errors++;
            $display("FAIL addi_wb: got v=%b ctrl=%b dst=%0d want 1/01/5",
                     wb_valid, wb_ctrl, wb_dst);
        end
        // ADDI targeting r0: reg_w must be suppressed
        drive(1, 6'b001000, 5'd1, 5'd0, 5'd9, 0);
        tick();
        idle();
        checks++;
        if ({ex_valid, ex_ctrl, ex_dst} !== {1'b1, 11'b00111000000, 5'd0}) begin
            errors++;
            $display("FAIL addi_r0: got v=%b ctrl=%b dst=%0d want 1/00111000000/0",
                     ex_valid, ex_ctrl, ex_dst);
        end
        tick();
        tick();
    endtask

    task automatic test_load_use();
        for (int unsigned k = 0; k < 2; k++) begin
            bit [4:0] d;
            bit       exp;
            d   = (k == 0) ? 5'd3 : 5'd0;
            exp = (k == 0);
            drive(1, 6'b100011, 5'd1, d, 5'd0, 0);
            tick();
            drive(1, 6'b000000, d, 5'd2, 5'd9, 0);
            #2;
            checks++;
            if (stall !== exp) begin
                errors++;
                $display("FAIL load_use_stall dst=%0d: got %b want %b", d, stall, exp);
            end
            tick();
            if (exp) begin
                checks++;
                if ({ex_valid, ex_ctrl} !== '0) begin
                    errors++;
                    $display("FAIL load_use_bubble: got v=%b ctrl=%b want 0/0", ex_valid, ex_ctrl);
                end
                #1;
                checks++;
                if (stall !== 1'b0) begin
                    errors++;
                    $display("FAIL load_use_one_cycle: got stall=%b want 0", stall);
                end
                tick();
            end
            idle();
            checks++;
            if ({ex_valid, ex_ctrl, ex_dst} !== {1'b1, 11'b01001000001, 5'd9}) begin
                errors++;
                $display("FAIL load_use_rtype_ex k=%0d: got v=%b ctrl=%b dst=%0d want 1/01001000001/9",
                         k, ex_valid, ex_ctrl, ex_dst);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_rt_read();
        bit [5:0] ops [3] = '{6'b101011, 6'b000100, 6'b001000};
        bit       exps[3] = '{1'b1, 1'b1, 1'b0};
        for (int unsigned k = 0; k < 3; k++) begin
            drive(1, 6'b100011, 5'd1, 5'd4, 5'd0, 0);
            tick();
            drive(1, ops[k], 5'd2, 5'd4, 5'd0, 0);
            #2;
            checks++;
            if (stall !== exps[k]) begin
                errors++;
                $display("FAIL rt_read_stall op=%b: got %b want %b", ops[k], stall, exps[k]);
            end
            tick();
            idle();
            checks++;
            if (ex_valid !== !exps[k]) begin
                errors++;
                $display("FAIL rt_read_ex_valid op=%b: got %b want %b", ops[k], ex_valid, !exps[k]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1, 6'b100011, 5'd1, 5'd6, 5'd0, 0);
        tick();
        drive(1, 6'b000000, 5'd6, 5'd1, 5'd3, 1);
        #2;
        checks++;
        if ({if_id_flush, stall} !== 2'b10) begin
            errors++;
            $display("FAIL flush_over_stall: got flush/stall=%b want 10", {if_id_flush, stall});
        end
        tick();
        idle();
        checks++;
        if ({ex_valid, ex_ctrl, ex_dst} !== '0) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b ctrl=%b dst=%0d want 0", ex_valid, ex_ctrl, ex_dst);
        end
        tick();
        tick();
    endtask

    task automatic test_illegal();
        drive(1, 6'b000010, 5'd1, 5'd2, 5'd3, 0);
        #2;
        checks++;
`ifdef JUMP_EN
        if ({jump, if_id_flush, illegal_op} !== 3'b110) begin
            errors++;
            $display("FAIL j_decode: got jump/flush/illegal=%b want 110", {jump, if_id_flush, illegal_op});
        end
`else
        if ({if_id_flush, illegal_op} !== 2'b01) begin
            errors++;
            $display("FAIL j_illegal: got flush/illegal=%b want 01", {if_id_flush, illegal_op});
        end
`endif
        tick();
        drive(1, 6'b111111, 5'd1, 5'd2, 5'd3, 0);
        #2;
        checks++;
        if ({ex_valid, ex_ctrl, illegal_op} !== {1'b0, 11'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_bubble: got ex_v=%b ctrl=%b illegal=%b want 0/0/1",
                     ex_valid, ex_ctrl, illegal_op);
        end
        id_valid = 1'b0;
        #1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL illegal_invalid: got %b want 0", illegal_op);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit [5:0] op_tab [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        m_ex  = blank();
        m_mem = blank();
        m_wb  = blank();
        tick();
        for (int unsigned cyc = 0; cyc < 600; cyc++) begin
            bit       v, br, legal, rtr, hz, jmp;
            bit [5:0] op;
            bit [4:0] rs, rt, rd;
            bit [2:0] exp_comb;
            int unsigned sel;
            ent_t     dec, nxt;
            v   = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 8);
            if (sel < 6)       op = op_tab[sel];
            else if (sel == 6) op = 6'($urandom);
            else               op = 6'b100011;
            rs = 5'($urandom_range(0, 5));
            rt = 5'($urandom_range(0, 5));
            rd = 5'($urandom_range(0, 5));
            drive(v, op, rs, rt, rd, br);
            #2;
            dec = ref_decode(op, rt, rd, legal, rtr);
            hz  = m_ex.v && m_ex.mem_r && v && (m_ex.dst != 0)
                  && ((m_ex.dst == rs) || (rtr && (m_ex.dst == rt)));
`ifdef JUMP_EN
            jmp = v && (op == 6'b000010) && !br;
            checks++;
            if (jump !== jmp) begin
                errors++;
                $display("FAIL rand_jump cyc=%0d: got %b want %b", cyc, jump, jmp);
            end
`else
            jmp = 1'b0;
`endif
            exp_comb = {hz && !br, br || jmp, v && !legal};
            checks++;
            if ({stall, if_id_flush, illegal_op} !== exp_comb) begin
                errors++;
                $display("FAIL rand_comb cyc=%0d: got stall/flush/illegal=%b want %b",
                         cyc, {stall, if_id_flush, illegal_op}, exp_comb);
            end
            checks++;
            if ({ex_valid, ex_dst, ex_ctrl} !== {m_ex.v, m_ex.dst, pack_ex(m_ex)}) begin
                errors++;
                $display("FAIL rand_ex cyc=%0d: got v=%b dst=%0d ctrl=%b want v=%b dst=%0d ctrl=%b",
                         cyc, ex_valid, ex_dst, ex_ctrl, m_ex.v, m_ex.dst, pack_ex(m_ex));
            end
            checks++;
            if ({mem_valid, mem_dst, mem_ctrl} !== {m_mem.v, m_mem.dst, pack_mem(m_mem)}) begin
                errors++;
                $display("FAIL rand_mem cyc=%0d: got v=%b dst=%0d ctrl=%b want v=%b dst=%0d ctrl=%b",
                         cyc, mem_valid, mem_dst, mem_ctrl, m_mem.v, m_mem.dst, pack_mem(m_mem));
            end
            checks++;
            if ({wb_valid, wb_dst, wb_ctrl} !== {m_wb.v, m_wb.dst, m_wb.mem_to_reg, m_wb.reg_w}) begin
                errors++;
                $display("FAIL rand_wb cyc=%0d: got v=%b dst=%0d ctrl=%b want v=%b dst=%0d ctrl=%b%b",
                         cyc, wb_valid, wb_dst, wb_ctrl, m_wb.v, m_wb.dst, m_wb.mem_to_reg, m_wb.reg_w);
            end
            nxt = (!v || !legal || hz || br || jmp) ? blank() : dec;
            @(posedge clk);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = nxt;
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        test_reset();
        test_addi();
        test_load_use();
        test_rt_read();
        test_flush();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
